// File: rtl/logic2048_line_engine.sv
// ============================================================================
// Module : logic2048_line_engine
// Desc   : Sequential 2048 single-line slide/merge engine, one tile per clock.
//          Define LOGIC2048_SCORE_EN to build the merge_score/merge_count logic.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module logic2048_line_engine #(
    parameter int N       = 4,
    parameter int W       = 4,
    parameter int SCORE_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 dir,
    input  logic [N*W-1:0]       line_in,
    output logic                 busy,
    output logic                 done,
    output logic [N*W-1:0]       line_out,
    output logic                 movable,
    output logic [SCORE_W-1:0]   merge_score,
    output logic [$clog2(N):0]   merge_count
);

    localparam int             IW       = $clog2(N);
    localparam int             CW       = $clog2(N) + 1;
    localparam logic [IW-1:0]  LAST     = IW'(N - 1);
    localparam logic [W-1:0]   MAX_TILE = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [N*W-1:0] cap_line;
    logic           cap_dir;
    logic [N*W-1:0] work;
    logic [W-1:0]   pend;
    logic           pend_vld;
    logic [IW-1:0]  step;
    logic [IW-1:0]  slot;

    logic [IW-1:0]  scan_pos, slot_pos;
    logic [W-1:0]   cur;
    logic           hit;
    logic           emit;
    logic [W-1:0]   emit_val;
    logic [W-1:0]   pend_nx;
    logic           pend_vld_nx;
    logic [N*W-1:0] flush_line;

    // Step/slot k maps to the k-th tile counted from the leading end.
    function automatic logic [IW-1:0] lead_pos(input logic [IW-1:0] k, input logic d);
        return d ? (LAST - k) : k;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SCAN;
            SCAN:    if (step == LAST) state_nx = FLUSH;
            FLUSH:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign scan_pos = lead_pos(step, cap_dir);
    assign slot_pos = lead_pos(slot, cap_dir);
    assign cur      = cap_line[scan_pos*W +: W];
    assign hit      = pend_vld && (cur != '0) && (pend == cur) && (cur != MAX_TILE);

    always_comb begin
        emit        = 1'b0;
        emit_val    = '0;
        pend_nx     = pend;
        pend_vld_nx = pend_vld;
        if (cur != '0) begin
            if (hit) begin
                emit        = 1'b1;
                emit_val    = cur + W'(1);
                pend_vld_nx = 1'b0;
            end else if (pend_vld) begin
                emit     = 1'b1;
                emit_val = pend;
                pend_nx  = cur;
            end else begin
                pend_vld_nx = 1'b1;
                pend_nx     = cur;
            end
        end
    end

    always_comb begin
        flush_line = work;
        if (pend_vld) flush_line[slot_pos*W +: W] = pend;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_line <= '0;
            cap_dir  <= 1'b0;
            work     <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            step     <= '0;
            slot     <= '0;
            line_out <= '0;
            movable  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (state == FLUSH);
            case (state)
                IDLE: begin
                    if (start) begin
                        cap_line <= line_in;
                        cap_dir  <= dir;
                        work     <= '0;
                        pend     <= '0;
                        pend_vld <= 1'b0;
                        step     <= '0;
                        slot     <= '0;
                    end
                end
                SCAN: begin
                    step     <= step + IW'(1);
                    pend     <= pend_nx;
                    pend_vld <= pend_vld_nx;
                    if (emit) begin
                        work[slot_pos*W +: W] <= emit_val;
                        slot                  <= slot + IW'(1);
                    end
                end
                FLUSH: begin
                    line_out <= flush_line;
                    movable  <= (flush_line != cap_line);
                end
                default: ;
            endcase
        end
    end

`ifdef LOGIC2048_SCORE_EN
    localparam logic [SCORE_W:0] SCORE_ONE = {{SCORE_W{1'b0}}, 1'b1};

    logic [SCORE_W-1:0] score, score_nx;
    logic [CW-1:0]      count;
    logic [31:0]        term_exp;
    logic [SCORE_W:0]   score_sum;

    // Any term that does not fit, or a carry out of the sum, pins the score at all-ones.
    always_comb begin
        term_exp  = 32'(cur) + 32'd1;
        score_sum = '0;
        score_nx  = score;
        if (term_exp >= 32'(SCORE_W)) begin
            score_nx = '1;
        end else begin
            score_sum = {1'b0, score} + (SCORE_ONE << term_exp);
            score_nx  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score       <= '0;
            count       <= '0;
            merge_score <= '0;
            merge_count <= '0;
        end else begin
            if (state == IDLE && start) begin
                score <= '0;
                count <= '0;
            end else if (state == SCAN && hit) begin
                score <= score_nx;
                count <= count + CW'(1);
            end
            if (state == FLUSH) begin
                merge_score <= score;
                merge_count <= count;
            end
        end
    end
`else
    assign merge_score = '0;
    assign merge_count = '0;
`endif

endmodule

`default_nettype wire
